// File: rtl/sim_player_pkg.sv
// sim_player_pkg
// Shared types and default constants for the event player.
//   ev_rec_t : event record layout {tm, sig, val, last} at default widths
//   state_e  : player FSM states
//   *_DEF    : default parameter values for sim_event_player / ev_fifo
package sim_player_pkg;

  localparam int TIME_W_DEF = 16;
  localparam int SIG_N_DEF  = 4;
  localparam int SIG_W_DEF  = 2;
  localparam int DEPTH_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Field order is shared with the parameterised record in sim_event_player,
  // so a FIFO word can be reinterpreted with either type.
  typedef struct packed {
    logic [TIME_W_DEF-1:0] tm;
    logic [SIG_W_DEF-1:0]  sig;
    logic                  val;
    logic                  last;
  } ev_rec_t;

endpackage

// File: rtl/ev_fifo.sv
// ev_fifo
// Synchronous FIFO holding packed event records for the player.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clr_i           synchronous flush (pointers and count to zero)
//   push_i, wdata_i write request / data (ignored when full, no bypass)
//   pop_i, rdata_o  read request / head-of-queue data (ignored when empty)
//   full_o, empty_o status flags
//   count_o         number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module ev_fifo
  import sim_player_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Fullness is judged on the registered count, so a pop in the same cycle
  // never frees a slot for a push into a full FIFO.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/sim_event_player.sv
// sim_event_player
// Replays a queue of timed events onto a small bank of output signals.
// Events are accepted into a FIFO; once started, a cycle timer runs and each
// head event whose time has been reached is applied to sig_out (one per cycle).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start                       begin playback from IDLE, restart from DONE
//   ev_valid/ev_ready           event handshake
//   ev_time/ev_sig/ev_val/ev_last  event record fields
//   sig_out                     replayed signal values
//   busy, done                  state RUN / state DONE
//   err                         sticky bad-index (or ordering) error
// Build option:
//   PLAYER_ORDER_CHECK_EN  when defined, an event whose time is earlier than
//                          the previously accepted one is dropped and sets err.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | after reset; events accepted, timer stopped, nothing applied
// RUN   | timer counting; due head events applied to sig_out
// DONE  | last event applied; intake closed, waiting for start
module sim_event_player
  import sim_player_pkg::*;
#(
  parameter int TIME_W = TIME_W_DEF,
  parameter int SIG_N  = SIG_N_DEF,
  parameter int SIG_W  = SIG_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ev_valid,
  output logic              ev_ready,
  input  logic [TIME_W-1:0] ev_time,
  input  logic [SIG_W-1:0]  ev_sig,
  input  logic              ev_val,
  input  logic              ev_last,
  output logic [SIG_N-1:0]  sig_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef struct packed {
    logic [TIME_W-1:0] tm;
    logic [SIG_W-1:0]  sig;
    logic              val;
    logic              last;
  } ev_t;

  localparam int REC_W = $bits(ev_t);
  localparam logic [TIME_W-1:0] TIMER_MAX = '1;

  state_e             state_q, state_d;
  logic [TIME_W-1:0]  timer_q, timer_d;
  logic [SIG_N-1:0]   sig_out_q, sig_out_d;
  logic               err_q, err_d;

  logic               accept, order_bad, fifo_push, pop, restart, idx_ok;
  logic               fifo_full, fifo_empty;
  logic [REC_W-1:0]   fifo_rdata;
  logic [$clog2(DEPTH):0] unused_fifo_cnt;
  ev_t                head, in_rec;

  assign ev_ready = !fifo_full && (state_q != ST_DONE);
  assign accept   = ev_valid && ev_ready;
  assign restart  = (state_q == ST_DONE) && start;

  assign in_rec = '{tm: ev_time, sig: ev_sig, val: ev_val, last: ev_last};
  assign head   = ev_t'(fifo_rdata);

`ifdef PLAYER_ORDER_CHECK_EN
  logic [TIME_W-1:0] last_time_q, last_time_d;

  assign order_bad = accept && (ev_time < last_time_q);

  // Dropped events do not move the reference time forward.
  always_comb begin
    last_time_d = last_time_q;
    if (restart)                     last_time_d = '0;
    else if (accept && !order_bad)   last_time_d = ev_time;
  end

  always_ff @(posedge clk) begin
    if (rst) last_time_q <= '0;
    else     last_time_q <= last_time_d;
  end
`else
  assign order_bad = 1'b0;
`endif

  assign fifo_push = accept && !order_bad;

  // Head pops once its time is reached; a late (out-of-order) event pops at once.
  assign pop    = (state_q == ST_RUN) && !fifo_empty && (head.tm <= timer_q);
  assign idx_ok = 32'(head.sig) < 32'(SIG_N);

  ev_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (restart),
    .push_i  (fifo_push),
    .wdata_i (in_rec),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (unused_fifo_cnt)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    sig_out_d = sig_out_q;
    err_d     = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          timer_d = '0;
        end
      end
      ST_RUN: begin
        if (timer_q != TIMER_MAX) timer_d = timer_q + 1'b1;
        if (pop) begin
          // An out-of-range index matches no bit, so sig_out is untouched.
          for (int i = 0; i < SIG_N; i++) begin
            if (head.sig == SIG_W'(i)) sig_out_d[i] = head.val;
          end
          if (!idx_ok)   err_d   = 1'b1;
          if (head.last) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          timer_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (order_bad) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      sig_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      sig_out_q <= sig_out_d;
      err_q     <= err_d;
    end
  end

  assign sig_out = sig_out_q;
  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign err     = err_q;

endmodule

// File: tb/tb_sim_event_player.sv
module tb_sim_event_player;
  import sim_player_pkg::*;

  localparam int TIME_W = 16;
  localparam int SIG_N  = 3;
  localparam int SIG_W  = 2;
  localparam int DEPTH  = 4;

`ifdef PLAYER_ORDER_CHECK_EN
  localparam bit ORD = 1'b1;
`else
  localparam bit ORD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, ev_valid, ev_ready, ev_val, ev_last, busy, done, err;
  logic [TIME_W-1:0] ev_time;
  logic [SIG_W-1:0]  ev_sig;
  logic [SIG_N-1:0]  sig_out;

  always #5 clk = ~clk;

  sim_event_player #(
    .TIME_W (TIME_W),
    .SIG_N  (SIG_N),
    .SIG_W  (SIG_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_time  (ev_time),
    .ev_sig   (ev_sig),
    .ev_val   (ev_val),
    .ev_last  (ev_last),
    .sig_out  (sig_out),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // sc: scenario id, at: timer reading in which the event is first visible
  typedef struct {
    int sc; int tm; int sig; bit val; bit last; int at; bit drop;
  } vec_t;

  typedef struct {
    int at; int sig; bit val; bit last;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;
  bit run_active = 1'b0;
  int tcnt = 0;
  logic [SIG_N-1:0] exp_sig = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock; tcnt tracks the DUT timer while playback runs.
  task automatic step();
    exp_t e;
    @(posedge clk);
    if (run_active) tcnt++;
    #1;
    if (run_active) begin
      if (sb.size() > 0 && sb[0].at < tcnt) begin
        chk("event_time", tcnt, sb[0].at);
        sb.delete(0);
      end
      if (sb.size() > 0 && sb[0].at == tcnt) begin
        e = sb.pop_front();
        if (e.sig < SIG_N) exp_sig[e.sig] = e.val;
        if (e.last) begin
          chk("done_at_last", done, 1);
          chk("busy_at_last", busy, 0);
          run_active = 1'b0;
        end
      end
      if (run_active) chk("busy_run", busy, 1);
    end
    chk("sig_out", sig_out, exp_sig);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; ev_valid = 1'b0;
    run_active = 1'b0; sb.delete(); exp_sig = '0;
    step();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", ev_ready, 1);
  endtask

  task automatic push_ev(input vec_t v);
    int guard = 0;
    ev_valid = 1'b1;
    ev_time  = TIME_W'(v.tm);
    ev_sig   = SIG_W'(v.sig);
    ev_val   = v.val;
    ev_last  = v.last;
    while (!ev_ready && guard < 50) begin
      step();
      guard++;
    end
    if (!ev_ready) begin
      chk("push_ready", ev_ready, 1);
      ev_valid = 1'b0;
      return;
    end
    if (!v.drop) sb.push_back('{v.at, v.sig, v.val, v.last});
    step();
    ev_valid = 1'b0;
  endtask

  task automatic run_scenario(input int sc);
    foreach (tbl[i]) if (tbl[i].sc == sc) push_ev(tbl[i]);
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
    run_active = 1'b1;
    tcnt = 0;
    chk("busy_on_start", busy, 1);
  endtask

  task automatic run_until_done();
    int guard = 0;
    while (run_active && guard < 300) begin
      step();
      guard++;
    end
    run_active = 1'b0;
    chk("done_end", done, 1);
    chk("busy_end", busy, 0);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ev_valid = 1'b0;
    ev_time = '0; ev_sig = '0; ev_val = 1'b0; ev_last = 1'b0;

    // basic three-event sequence
    tbl.push_back('{0,  0, 0, 1'b0, 1'b0,  1, 1'b0});
    tbl.push_back('{0, 10, 1, 1'b1, 1'b0, 11, 1'b0});
    tbl.push_back('{0, 20, 0, 1'b1, 1'b1, 21, 1'b0});
    // restart from DONE, three events sharing time 5
    tbl.push_back('{1,  5, 2, 1'b1, 1'b0,  6, 1'b0});
    tbl.push_back('{1,  5, 0, 1'b0, 1'b0,  7, 1'b0});
    tbl.push_back('{1,  5, 2, 1'b0, 1'b1,  8, 1'b0});
    // bad index then a good one
    tbl.push_back('{2,  3, 3, 1'b1, 1'b0,  4, 1'b0});
    tbl.push_back('{2,  4, 1, 1'b1, 1'b1,  5, 1'b0});
    // out-of-order time
    tbl.push_back('{3, 10, 0, 1'b1, 1'b0, 11, 1'b0});
    tbl.push_back('{3,  4, 1, 1'b1, 1'b0, 12, ORD});
    tbl.push_back('{3, 12, 2, 1'b1, 1'b1, 13, 1'b0});
    // fill to DEPTH
    tbl.push_back('{4,  0, 0, 1'b1, 1'b0,  1, 1'b0});
    tbl.push_back('{4,  1, 1, 1'b1, 1'b0,  2, 1'b0});
    tbl.push_back('{4,  2, 2, 1'b1, 1'b0,  3, 1'b0});
    tbl.push_back('{4,  3, 0, 1'b0, 1'b1,  4, 1'b0});
    // reset mid-run
    tbl.push_back('{5,  0, 3, 1'b1, 1'b0,  1, 1'b0});
    tbl.push_back('{5,  1, 0, 1'b1, 1'b0,  2, 1'b0});
    tbl.push_back('{5, 50, 1, 1'b1, 1'b0, 51, 1'b0});
    tbl.push_back('{5, 60, 2, 1'b1, 1'b1, 61, 1'b0});

    do_reset();

    run_scenario(0);
    start_run();
    run_until_done();
    chk("A_final", sig_out, 3'b011);

    chk("ready_in_done", ev_ready, 0);
    start_run();
    run_scenario(1);
    run_until_done();
    chk("B_final", sig_out, 3'b010);

    do_reset();
    run_scenario(2);
    chk("C_err_before", err, 0);
    start_run();
    run_until_done();
    chk("C_err", err, 1);
    chk("C_final", sig_out, 3'b010);

    do_reset();
    run_scenario(3);
`ifdef PLAYER_ORDER_CHECK_EN
    chk("D_order_err", err, 1);
`else
    chk("D_order_err", err, 0);
`endif
    start_run();
    run_until_done();
`ifdef PLAYER_ORDER_CHECK_EN
    chk("D_final", sig_out, 3'b101);
`else
    chk("D_final", sig_out, 3'b111);
`endif

    do_reset();
    run_scenario(4);
    chk("full_ready", ev_ready, 0);
    ev_valid = 1'b1; ev_time = 16'd4; ev_sig = 2'd1; ev_val = 1'b0; ev_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("full_hold", ev_ready, 0);
    end
    ev_valid = 1'b0;
    start_run();
    run_until_done();
    chk("F_final", sig_out, 3'b110);

    do_reset();
    run_scenario(5);
    start_run();
    repeat (5) step();
    chk("E_err_set", err, 1);
    chk("E_mid_sig", sig_out, 3'b001);
    run_active = 1'b0;
    do_reset();
    start_run();
    repeat (80) step();
    chk("E_no_done", done, 0);
    chk("E_no_err", err, 0);
    run_active = 1'b0;
    do_reset();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sim_event_player.md
SIM_EVENT_PLAYER -- requirements
Module: sim_event_player

Interface
REQ-001 Parameters SHALL be: TIME_W, default 16, event time width in cycles; SIG_N, default 4, number of driven signals; SIG_W, default 2, signal index width (2**SIG_W >= SIG_N); DEPTH, default 4, event FIFO entries (power of two, >= 2).
REQ-002 Ports SHALL be:
 clk  in  1  single clock, rising edge.
 rst  in  1  synchronous, active-high reset.
 start  in  1  begin playback (level sampled each cycle).
 ev_valid  in  1  event record offered.
 ev_ready  out  1  player accepts the record this cycle.
 ev_time  in  TIME_W  cycle at which the event applies.
 ev_sig  in  SIG_W  index of the target signal.
 ev_val  in  1  value to drive.
 ev_last  in  1  final event of the sequence.
 sig_out  out  SIG_N  replayed signal values.
 busy  out  1  high in RUN.
 done  out  1  high in DONE.
 err  out  1  sticky ordering or index error.

Function
REQ-003 A transfer SHALL occur on a rising edge where ev_valid and ev_ready are both 1; ev_ready = FIFO not full and state != DONE; no bypass on a full FIFO, even with a same-cycle pop.
REQ-004 The FSM SHALL have states IDLE, RUN, DONE: IDLE->RUN on start=1; RUN->DONE on the cycle the ev_last entry is applied; DONE->RUN on start=1 while done=1; all other cases hold state.
REQ-005 On entry to RUN the timer SHALL load 0; in RUN it SHALL increment by 1 per cycle and saturate at 2**TIME_W-1 (no wrap).
REQ-006 In RUN, when the FIFO is non-empty and head.time <= timer, the head SHALL pop and sig_out[head.sig] SHALL take head.val at that edge, so an event with time T is visible on sig_out in the cycle where the timer reads T+1.
REQ-007 At most one event SHALL be applied per cycle; events sharing a time SHALL apply on consecutive cycles in FIFO order.
REQ-008 An event with ev_sig >= SIG_N SHALL be accepted, popped without changing sig_out, and SHALL set err.
REQ-009 Events SHALL be accepted in IDLE and RUN; no pops occur in IDLE or DONE.
REQ-010 sig_out SHALL hold its values across DONE->RUN; the FIFO and the last-accepted time SHALL be cleared on entry to RUN from DONE.
REQ-011 A push and a pop in the same cycle on a non-empty, non-full FIFO SHALL both take effect, leaving the count unchanged.
REQ-012 err SHALL remain set until rst.

Reset
REQ-013 On rst=1 the block SHALL clear the state to IDLE, the timer, the FIFO pointers and count, the last-accepted time, sig_out, busy, done and err, all to 0, at the next edge; ev_ready SHALL be 1 in the following cycle.
REQ-014 rst asserted mid-RUN SHALL discard every queued event and every partial sequence.

Configuration
REQ-015 With the macro PLAYER_ORDER_CHECK_EN defined, an accepted event whose ev_time is less than the previously accepted ev_time SHALL set err and SHALL be dropped (not queued).
REQ-016 Without PLAYER_ORDER_CHECK_EN, out-of-order events SHALL be queued normally and applied per REQ-006 (immediately once reached); err SHALL then reflect only REQ-008.

Structure
REQ-017 Package sim_player_pkg SHALL hold the event record typedef (time, sig, val, last), the FSM state enum, and the default parameter constants.
REQ-018 The FIFO SHALL be a sub-module named ev_fifo (synchronous, DEPTH entries, full/empty/count outputs); the FSM, timer and sig_out logic stay in sim_event_player.

Verification
REQ-019 Reset, then push (0,x=0,0),(10,y=1,1),(20,x=1,1,last); then start -> sig_out[1] rises at timer 11, sig_out[0] at timer 21, done=1 and busy=0 the cycle after.
REQ-020 Push DEPTH events with start=0 -> ev_ready=0 after the DEPTH-th transfer; a further ev_valid is not accepted and the count stays DEPTH.
REQ-021 Three events all at time 5 -> applied at timer 5, 6 and 7 in push order; the final sig_out matches the last value written per index.
REQ-022 With PLAYER_ORDER_CHECK_EN, push times 10 then 4 -> err=1, the time-4 event never appears on sig_out; without the macro it applies at timer 10+1.
REQ-023 ev_sig=3 with SIG_N=3 -> err=1 and sig_out unchanged; rst mid-RUN with 2 events queued -> IDLE, sig_out=0, FIFO empty, err=0.
REQ-024 From DONE, start=1 with a new sequence queued -> timer restarts at 0 and sig_out keeps its prior values until the first new event applies.
